imem_loader: RTL

//  Byte-stream program loader: writes the instruction memory that the single-cycle CPU fetches from.

---
 rtl/imem_loader.sv | 128 ++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Program loader: turns a length-prefixed byte stream into big-endian 32-bit words
// written to the instruction memory, holding the CPU in reset until the image is complete.
module imem_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DATA, DONE, ERR} state_e;

   localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

   state_e            state_q, state_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [15:0]       widx_q, widx_d;
   logic [1:0]        bidx_q, bidx_d;
   logic [31:0]       shift_q, shift_d;
   logic              last_q, last_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              xfer;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         widx_q  <= '0;
         bidx_q  <= '0;
         shift_q <= '0;
         last_q  <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         widx_q  <= widx_d;
         bidx_q  <= bidx_d;
         shift_q <= shift_d;
         last_q  <= last_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // last_q marks the write cycle of the final word: no more bytes are taken then.
   assign in_ready = (state_q == HDR_HI) || (state_q == HDR_LO) ||
                     ((state_q == DATA) && !last_q);
   assign xfer     = in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      widx_d  = widx_q;
      bidx_d  = bidx_q;
      shift_d = shift_q;
      last_d  = last_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      unique case (state_q)
         IDLE: begin
            if (start) state_d = HDR_HI;
         end
         HDR_HI: begin
            if (xfer) begin
               cnt_d[15:8] = in_data;
               state_d     = HDR_LO;
            end
         end
         HDR_LO: begin
            if (xfer) begin
               cnt_d  = {cnt_q[15:8], in_data};
               widx_d = '0;
               bidx_d = '0;
               last_d = 1'b0;
               if (cnt_d == 16'd0)              state_d = DONE;
               else if ({1'b0, cnt_d} > DEPTH) state_d = ERR;
               else                             state_d = DATA;
            end
         end
         DATA: begin
            if (last_q) begin
               last_d  = 1'b0;
               state_d = DONE;
            end else if (xfer) begin
               shift_d = {shift_q[23:0], in_data};
               bidx_d  = bidx_q + 2'd1;
               if (bidx_q == 2'd3) begin
                  we_d    = 1'b1;
                  addr_d  = widx_q[ADDR_W-1:0];
                  wdata_d = {shift_q[23:0], in_data};
                  widx_d  = widx_q + 16'd1;
                  if (widx_q == cnt_q - 16'd1) last_d = 1'b1;
               end
            end
         end
         DONE: begin
            if (start) state_d = HDR_HI;
         end
         ERR: begin
            if (start) state_d = HDR_HI;
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign done      = (state_q == DONE);
   assign err       = (state_q == ERR);
   assign cpu_hold  = (state_q != DONE);

endmodule
